// File: rtl/count_seq_monitor_pkg.sv
// ---------------------------------------------------------------------------
// count_seq_monitor_pkg
// Shared types and constants for the count sequence monitor.
//   state_t : FSM state encoding, also driven out on the 2-bit state port
//             (IDLE=0, TRACK=1, LOCKED=2, FAULT=3).
//   RUN_W   : width of the consecutive-match run counter.
// ---------------------------------------------------------------------------
package count_seq_monitor_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_TRACK  = 2'd1,
      S_LOCKED = 2'd2,
      S_FAULT  = 2'd3
   } state_t;

   localparam int unsigned RUN_W = 4;

endpackage : count_seq_monitor_pkg

// File: rtl/count_seq_monitor_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous clear.
//   CLK   : rising-edge clock
//   RESET : synchronous, active-high clear
//   inc   : increment request, ignored once count is all-ones
//   count : current count value (W bits)
// ---------------------------------------------------------------------------
module sat_counter #(
   parameter int unsigned W = 8
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + W'(1);
      end
   end

endmodule : sat_counter

// File: rtl/count_seq_monitor.sv
// ---------------------------------------------------------------------------
// count_seq_monitor
// Watches a free-running binary up-counter and checks that successive valid
// samples step by +1 modulo 2^WIDTH. After LOCK_COUNT consecutive correct
// steps the monitor locks; while locked it counts completed wraps and flags
// any sequence break as a fault.
//   CLK        : rising-edge clock
//   RESET      : synchronous, active-high reset
//   in_valid   : qualifies in_cnt; everything holds while low
//   in_cnt     : monitored counter value (WIDTH bits)
//   locked     : high while the FSM is in LOCKED
//   err_pulse  : one-cycle pulse per fault detected while LOCKED
//   state      : current FSM state encoding
//   wrap_count : wraps seen while LOCKED, saturating (WRAP_W bits)
//   err_count  : faults detected, saturating (ERR_W bits)
// ---------------------------------------------------------------------------
module count_seq_monitor
   import count_seq_monitor_pkg::*;
#(
   parameter int unsigned WIDTH      = 3,
   parameter int unsigned LOCK_COUNT = 4,
   parameter int unsigned WRAP_W     = 8,
   parameter int unsigned ERR_W      = 4
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              in_valid,
   input  logic [WIDTH-1:0]  in_cnt,
   output logic              locked,
   output logic              err_pulse,
   output logic [1:0]        state,
   output logic [WRAP_W-1:0] wrap_count,
   output logic [ERR_W-1:0]  err_count
);

   localparam logic [RUN_W-1:0] LOCK_RUN = RUN_W'(LOCK_COUNT);

   state_t             state_q, state_n;
   logic [WIDTH-1:0]   prev_q, prev_n;
   logic [RUN_W-1:0]   run_q, run_n;
   logic               err_q, err_n;
   logic [WIDTH-1:0]   expect_cnt;
   logic               match;
   logic               wrap_hit;
   logic               wrap_inc;
   logic               err_inc;

   // Expected next value uses a WIDTH-bit add so all-ones wraps to zero.
   assign expect_cnt = prev_q + WIDTH'(1);
   assign match      = (in_cnt == expect_cnt);
   assign wrap_hit   = match && (prev_q == '1);

   // State register
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= S_IDLE;
         prev_q  <= '0;
         run_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_n;
         prev_q  <= prev_n;
         run_q   <= run_n;
         err_q   <= err_n;
      end
   end

   // Next-state logic; the counter increment requests are combinational so
   // the saturating counters update on the same edge as the FSM.
   always_comb begin
      state_n  = state_q;
      prev_n   = prev_q;
      run_n    = run_q;
      err_n    = 1'b0;
      wrap_inc = 1'b0;
      err_inc  = 1'b0;
      if (in_valid) begin
         prev_n = in_cnt;
         unique case (state_q)
            S_IDLE: begin
               state_n = S_TRACK;
               run_n   = '0;
            end
            S_TRACK: begin
               if (match) begin
                  if ((run_q + RUN_W'(1)) == LOCK_RUN) begin
                     state_n = S_LOCKED;
                     run_n   = '0;
                  end else begin
                     run_n = run_q + RUN_W'(1);
                  end
               end else begin
                  run_n = '0;
               end
            end
            S_LOCKED: begin
               if (match) begin
                  wrap_inc = wrap_hit;
               end else begin
                  state_n = S_FAULT;
                  err_n   = 1'b1;
                  err_inc = 1'b1;
               end
            end
            S_FAULT: begin
               state_n = S_TRACK;
               run_n   = '0;
            end
            default: begin
               state_n = S_IDLE;
               run_n   = '0;
            end
         endcase
      end
   end

   // Output logic: all outputs come straight from registers.
   always_comb begin
      state     = state_q;
      locked    = (state_q == S_LOCKED);
      err_pulse = err_q;
   end

   sat_counter #(
      .W (WRAP_W)
   ) u_wrap_counter (
      .CLK   (CLK),
      .RESET (RESET),
      .inc   (wrap_inc),
      .count (wrap_count)
   );

   sat_counter #(
      .W (ERR_W)
   ) u_err_counter (
      .CLK   (CLK),
      .RESET (RESET),
      .inc   (err_inc),
      .count (err_count)
   );

endmodule : count_seq_monitor

// File: tb/tb_count_seq_monitor.sv
// ---------------------------------------------------------------------------
// tb_count_seq_monitor
// Self-checking bench for count_seq_monitor: a hand-computed vector table,
// randomized stimulus against a behavioural reference model, and directed
// sequences for counter saturation and reset while locked. A second instance
// with WRAP_W=2 shares the stimulus to exercise wrap-counter saturation.
// ---------------------------------------------------------------------------
module tb_count_seq_monitor;

   logic       CLK = 1'b0;
   logic       RESET;
   logic       in_valid;
   logic [2:0] in_cnt;

   logic       locked, err_pulse;
   logic [1:0] state;
   logic [7:0] wrap_count;
   logic [3:0] err_count;

   logic       locked2, err_pulse2;
   logic [1:0] state2;
   logic [1:0] wrap_count2;
   logic [3:0] err_count2;

   int errors = 0;
   int checks = 0;

   always #5 CLK = ~CLK;

   count_seq_monitor #(
      .WIDTH      (3),
      .LOCK_COUNT (4),
      .WRAP_W     (8),
      .ERR_W      (4)
   ) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .in_valid   (in_valid),
      .in_cnt     (in_cnt),
      .locked     (locked),
      .err_pulse  (err_pulse),
      .state      (state),
      .wrap_count (wrap_count),
      .err_count  (err_count)
   );

   count_seq_monitor #(
      .WIDTH      (3),
      .LOCK_COUNT (4),
      .WRAP_W     (2),
      .ERR_W      (4)
   ) dut2 (
      .CLK        (CLK),
      .RESET      (RESET),
      .in_valid   (in_valid),
      .in_cnt     (in_cnt),
      .locked     (locked2),
      .err_pulse  (err_pulse2),
      .state      (state2),
      .wrap_count (wrap_count2),
      .err_count  (err_count2)
   );

   // ---------------- reference model (unbounded totals, clipped on compare)
   int m_state, m_prev, m_run, m_wraps, m_errs, m_pulse;
   int tx_prev; // last value driven, for building sequences

   function automatic int clip(int v, int maxv);
      return (v > maxv) ? maxv : v;
   endfunction

   task automatic model_step(input bit rst, input bit v, input int c);
      bit good;
      if (rst) begin
         m_state = 0; m_prev = 0; m_run = 0;
         m_wraps = 0; m_errs = 0; m_pulse = 0;
      end else if (!v) begin
         m_pulse = 0;
      end else begin
         good    = (c == ((m_prev + 1) % 8));
         m_pulse = 0;
         if (m_state == 0) begin
            m_state = 1; m_run = 0;
         end else if (m_state == 1) begin
            if (!good) m_run = 0;
            else if (m_run + 1 == 4) begin m_state = 2; m_run = 0; end
            else m_run = m_run + 1;
         end else if (m_state == 2) begin
            if (good && m_prev == 7) m_wraps = m_wraps + 1;
            if (!good) begin m_state = 3; m_pulse = 1; m_errs = m_errs + 1; end
         end else begin
            m_state = 1; m_run = 0;
         end
         m_prev = c;
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input bit rst, input bit v, input int c);
      RESET    = rst;
      in_valid = v;
      in_cnt   = 3'(c);
      if (v && !rst) tx_prev = c;
      if (rst) tx_prev = 0;
      @(posedge CLK);
      #1;
   endtask

   // Apply one sample and compare both instances against the model.
   task automatic send(input bit rst, input bit v, input int c);
      drive(rst, v, c);
      model_step(rst, v, c);
      chk("state",      int'(state),       m_state);
      chk("locked",     int'(locked),      (m_state == 2) ? 1 : 0);
      chk("err_pulse",  int'(err_pulse),   m_pulse);
      chk("wrap_count", int'(wrap_count),  clip(m_wraps, 255));
      chk("err_count",  int'(err_count),   clip(m_errs, 15));
      chk("state2",     int'(state2),      m_state);
      chk("wrap2",      int'(wrap_count2), clip(m_wraps, 3));
      chk("err2",       int'(err_count2),  clip(m_errs, 15));
   endtask

   task automatic next_ok();
      send(1'b0, 1'b1, (tx_prev + 1) % 8);
   endtask

   // ---------------- vector table
   typedef struct {
      bit rst;
      bit v;
      int c;
      int st;
      int lk;
      int ep;
      int wc;
      int ec;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(bit rst, bit v, int c, int st, int lk, int ep, int wc, int ec);
      vec_t e;
      e.rst = rst; e.v = v; e.c = c;
      e.st = st; e.lk = lk; e.ep = ep; e.wc = wc; e.ec = ec;
      tbl.push_back(e);
   endfunction

   initial begin
      RESET    = 1'b1;
      in_valid = 1'b0;
      in_cnt   = '0;
      tx_prev  = 0;
      model_step(1'b1, 1'b0, 0);

      // lock-up, wrap while locked, fault and relock
      add(1,0,0, 0,0,0,0,0);
      add(1,0,0, 0,0,0,0,0);
      add(0,1,0, 1,0,0,0,0);
      add(0,1,1, 1,0,0,0,0);
      add(0,1,2, 1,0,0,0,0);
      add(0,1,3, 1,0,0,0,0);
      add(0,1,4, 2,1,0,0,0);
      add(0,1,5, 2,1,0,0,0);
      add(0,1,6, 2,1,0,0,0);
      add(0,1,7, 2,1,0,0,0);
      add(0,1,0, 2,1,0,1,0);
      add(0,1,1, 2,1,0,1,0);
      add(0,1,2, 2,1,0,1,0);
      add(0,1,3, 2,1,0,1,0);
      add(0,1,5, 3,0,1,1,1);
      add(0,0,5, 3,0,0,1,1);
      add(0,1,6, 1,0,0,1,1);
      add(0,1,7, 1,0,0,1,1);
      add(0,1,0, 1,0,0,1,1);
      add(0,1,1, 1,0,0,1,1);
      add(0,1,2, 2,1,0,1,1);
      // in_valid gaps during acquisition
      add(1,0,0, 0,0,0,0,0);
      add(0,1,0, 1,0,0,0,0);
      add(0,1,1, 1,0,0,0,0);
      add(0,0,1, 1,0,0,0,0);
      add(0,0,1, 1,0,0,0,0);
      add(0,1,2, 1,0,0,0,0);
      add(0,1,3, 1,0,0,0,0);
      add(0,0,3, 1,0,0,0,0);
      add(0,1,4, 2,1,0,0,0);
      add(0,0,4, 2,1,0,0,0);

      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].v, tbl[i].c);
         chk($sformatf("tbl%0d.state", i),  int'(state),      tbl[i].st);
         chk($sformatf("tbl%0d.locked", i), int'(locked),     tbl[i].lk);
         chk($sformatf("tbl%0d.pulse", i),  int'(err_pulse),  tbl[i].ep);
         chk($sformatf("tbl%0d.wrap", i),   int'(wrap_count), tbl[i].wc);
         chk($sformatf("tbl%0d.errc", i),   int'(err_count),  tbl[i].ec);
      end

      // ---------------- randomized stimulus against the model
      send(1'b1, 1'b0, 0);
      for (int i = 0; i < 600; i++) begin
         bit r, v;
         int c;
         r = ($urandom_range(0, 199) == 0);
         v = ($urandom_range(0, 4) != 0);
         c = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 7))
                                           : (tx_prev + 1) % 8;
         send(r, v, c);
      end

      // ---------------- 17 faults: error counter saturates at 15
      send(1'b1, 1'b0, 0);
      send(1'b0, 1'b1, 0);
      for (int k = 0; k < 4; k++) next_ok();
      for (int f = 0; f < 17; f++) begin
         send(1'b0, 1'b1, (tx_prev + 3) % 8);   // fault while locked
         send(1'b0, 1'b1, (tx_prev + 5) % 8);   // leaves FAULT, no extra error
         for (int k = 0; k < 4; k++) next_ok(); // relock
      end
      chk("err_sat", int'(err_count), 15);
      chk("err_sat2", int'(err_count2), 15);

      // ---------------- 5 full wraps: WRAP_W=2 instance saturates at 3
      send(1'b1, 1'b0, 0);
      send(1'b0, 1'b1, 0);
      for (int k = 0; k < 4; k++) next_ok();
      for (int k = 0; k < 40; k++) next_ok();
      chk("wrap_full", int'(wrap_count), 5);
      chk("wrap_sat2", int'(wrap_count2), 3);

      // ---------------- reset while locked with wrap_count=2
      send(1'b1, 1'b0, 0);
      send(1'b0, 1'b1, 0);
      for (int k = 0; k < 4; k++) next_ok();
      for (int k = 0; k < 12; k++) next_ok();  // 4->0 and 7->0 again
      chk("pre_rst_wrap", int'(wrap_count), 2);
      chk("pre_rst_lock", int'(locked), 1);
      send(1'b1, 1'b1, 5);
      chk("rst_lock", int'(locked), 0);
      chk("rst_state", int'(state), 0);
      chk("rst_wrap", int'(wrap_count), 0);
      chk("rst_errc", int'(err_count), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_count_seq_monitor
